// File: rtl/hazard_pkg.sv
// Shared types for the multi-cycle hazard unit.
//   fwd_sel_t  : E-stage operand forwarding select (RF / writeback / memory)
//   mc_state_t : state of the multi-cycle execute FSM
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MC_IDLE,
        MC_BUSY
    } mc_state_t;

endpackage : hazard_pkg

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high reset (count -> 0)
//   clr    : synchronous clear, wins over inc
//   inc    : count one event this cycle
//   count  : current value, sticks at all-ones
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : hazard_sat_counter

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit for the 5-stage ARM core (F/D/E/M/W) with a
// multi-cycle execute stage.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   RA1D/RA2D, RA1E/RA2E            : D- and E-stage source registers
//   WA3E/WA3M/WA3W, RegWrite{E,M,W} : destinations and write enables
//   MemToRegE                       : E-stage instruction is a load
//   PCSrc{D,E,M,W}, BranchTakenE    : PC writes in flight / taken branch
//   MulStartE                       : E-stage instruction is multi-cycle
//   CntClr                          : synchronous clear of both counters
//   StallF/D/E, FlushD/E/M          : pipeline register control
//   ForwardAE/BE                    : 00 RF, 01 W, 10 M
//   MulBusy                         : multi-cycle op occupies E
//   StallCount/FlushCount           : saturating event counters
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int NREGS   = 16,
    parameter int REG_W   = $clog2(NREGS),
    parameter int PC_REG  = 15,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] WA3E,
    input  logic [REG_W-1:0] WA3M,
    input  logic [REG_W-1:0] WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MulStartE,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

    // A one-cycle op needs no extra E cycles, so the FSM is disabled outright.
    localparam bit MC_EN = (MUL_LAT > 1);

    // BUSY covers the MUL_LAT-1 cycles after the start cycle; cnt counts the
    // remaining stall cycles, so it only needs to hold MUL_LAT-2.
    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = MC_EN ? CW'(MUL_LAT - 2) : '0;

    // ---------------------------------------------------------------- forwarding
    function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] ra,
                                         input logic             rw_m,
                                         input logic [REG_W-1:0] wa_m,
                                         input logic             rw_w,
                                         input logic [REG_W-1:0] wa_w);
        fwd_sel_t sel;
        sel = FWD_RF;
        // The PC is read from its own path, never from the bypass network.
        if (ra != PC_IDX) begin
            if (rw_m && (wa_m == ra)) begin
                sel = FWD_MEM;
            end else if (rw_w && (wa_w == ra)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    fwd_sel_t fwd_a, fwd_b;

    assign fwd_a     = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign fwd_b     = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    // ---------------------------------------------------------------- load-use
    logic ldr_stall;

    assign ldr_stall = MemToRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

    // ---------------------------------------------------------------- multi-cycle FSM
    mc_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          mul_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        unique case (state_q)
            MC_IDLE: begin
                if (MulStartE && MC_EN) begin
                    mul_stall = 1'b1;
                    state_d   = MC_BUSY;
                    cnt_d     = CNT_INIT;
                end
            end
            MC_BUSY: begin
                // MulStartE is ignored here: the op already in E owns the stage.
                if (cnt_q != '0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d = MC_IDLE;
                end
            end
        endcase
    end

    assign MulBusy = (state_q == MC_BUSY) | ((state_q == MC_IDLE) & MulStartE & MC_EN);

    // ---------------------------------------------------------------- stage control
    logic pc_wr_pending;

    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    assign StallF = ldr_stall | pc_wr_pending | mul_stall;
    assign StallD = ldr_stall | mul_stall;
    assign StallE = mul_stall;
    // A multi-cycle op holds D and E, so their contents must survive: the
    // stall masks any flush that would otherwise hit those registers.
    assign FlushD = (pc_wr_pending | PCSrcW | BranchTakenE) & ~mul_stall;
    assign FlushE = (ldr_stall | BranchTakenE) & ~mul_stall;
    assign FlushM = mul_stall;

    // ---------------------------------------------------------------- counters
    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (StallD),
        .count (StallCount)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (FlushE),
        .count (FlushCount)
    );

endmodule : hazard_unit_mc

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc. Three instances share one set of inputs:
// u_dut (defaults, MUL_LAT=3), u_lat1 (MUL_LAT=1) and u_sat (CNT_W=2).
module tb_hazard_unit_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE, CntClr;

    // main instance outputs
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount, FlushCount;
    // MUL_LAT=1 instance outputs
    logic        l_sf, l_sd, l_se, l_fd, l_fe, l_fm, l_busy;
    logic [1:0]  l_fa, l_fb;
    logic [15:0] l_scnt, l_fcnt;
    // CNT_W=2 instance outputs
    logic        s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_busy;
    logic [1:0]  s_fa, s_fb;
    logic [1:0]  s_scnt, s_fcnt;

    hazard_unit_mc u_dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulBusy(MulBusy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit_mc #(.MUL_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .CntClr(CntClr),
        .StallF(l_sf), .StallD(l_sd), .StallE(l_se),
        .FlushD(l_fd), .FlushE(l_fe), .FlushM(l_fm),
        .ForwardAE(l_fa), .ForwardBE(l_fb), .MulBusy(l_busy),
        .StallCount(l_scnt), .FlushCount(l_fcnt)
    );

    hazard_unit_mc #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .CntClr(CntClr),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se),
        .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm),
        .ForwardAE(s_fa), .ForwardBE(s_fb), .MulBusy(s_busy),
        .StallCount(s_scnt), .FlushCount(s_fcnt)
    );

    // ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    typedef struct {
        string      name;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwe, rwm, rww, m2r, pcd, pce, pcm, pcw, bte;
        logic [5:0] exp_ctl;
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n,
                                input logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
                                input logic [8:0] flags, // {rwe,rwm,rww,m2r,pcd,pce,pcm,pcw,bte}
                                input logic [5:0] ctl, input logic [1:0] fa, fb);
        vec_t v;
        v.name = n;
        v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
        v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
        {v.rwe, v.rwm, v.rww, v.m2r, v.pcd, v.pce, v.pcm, v.pcw, v.bte} = flags;
        v.exp_ctl = ctl; v.exp_fa = fa; v.exp_fb = fb;
        return v;
    endfunction

    task automatic idle_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemToRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE, CntClr} = '0;
    endtask

    task automatic drive(input vec_t v);
        RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww; MemToRegE = v.m2r;
        PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw;
        BranchTakenE = v.bte;
        sb.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t exp_v;

        //            name         ra1d ra2d ra1e ra2e wa3e wa3m wa3w  rwe,rwm,rww,m2r,pcd,pce,pcm,pcw,bte  ctl       fa     fb
        vecs.push_back(mk("zero",     0,   0,   0,   0,   0,   0,   0, 9'b000000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("m_beats_w",0,   0,   3,   3,   0,   3,   3, 9'b011000000, 6'b000000, 2'b10, 2'b10));
        vecs.push_back(mk("w_only",   0,   0,   3,   3,   0,   3,   3, 9'b001000000, 6'b000000, 2'b01, 2'b01));
        vecs.push_back(mk("pc_a",     0,   0,  15,   3,   0,  15,   3, 9'b011000000, 6'b000000, 2'b00, 2'b01));
        vecs.push_back(mk("reg0_fwd", 0,   0,   0,   0,   0,   0,   0, 9'b010000000, 6'b000000, 2'b10, 2'b10));
        vecs.push_back(mk("pc_b_w",   0,   0,   1,  15,   0,   2,  15, 9'b011000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("ldr_ra2",  1,   5,   0,   0,   5,   0,   0, 9'b100100000, 6'b110010, 2'b00, 2'b00));
        vecs.push_back(mk("ldr_both", 5,   5,   0,   0,   5,   0,   0, 9'b100100000, 6'b110010, 2'b00, 2'b00));
        vecs.push_back(mk("ld_no_rw", 5,   5,   0,   0,   5,   0,   0, 9'b000100000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("branch",   0,   0,   0,   0,   0,   0,   0, 9'b000000001, 6'b000110, 2'b00, 2'b00));
        vecs.push_back(mk("pcsrc_d",  0,   0,   0,   0,   0,   0,   0, 9'b000010000, 6'b100100, 2'b00, 2'b00));
        vecs.push_back(mk("pcsrc_e",  0,   0,   0,   0,   0,   0,   0, 9'b000001000, 6'b100100, 2'b00, 2'b00));
        vecs.push_back(mk("pcsrc_m",  0,   0,   0,   0,   0,   0,   0, 9'b000000100, 6'b100100, 2'b00, 2'b00));
        vecs.push_back(mk("pcsrc_w",  0,   0,   0,   0,   0,   0,   0, 9'b000000010, 6'b000100, 2'b00, 2'b00));
        vecs.push_back(mk("ldr_br",   5,   1,   0,   0,   5,   0,   0, 9'b100100001, 6'b110110, 2'b00, 2'b00));

        // ---- asynchronous reset state, all inputs 0
        idle_inputs();
        reset = 1'b1;
        #3;
        check("reset_ctl", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy}, 7'b0);
        check("reset_fwd", {ForwardAE, ForwardBE}, 4'b0);
        check("reset_cnt", {StallCount, FlushCount}, 32'b0);
        next_cycle();
        reset = 1'b0;

        // ---- combinational table through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            check({exp_v.name, "_ctl"}, {StallF, StallD, StallE, FlushD, FlushE, FlushM}, exp_v.exp_ctl);
            check({exp_v.name, "_fa"}, ForwardAE, exp_v.exp_fa);
            check({exp_v.name, "_fb"}, ForwardBE, exp_v.exp_fb);
            next_cycle();
        end
        check("sb_empty", sb.size(), 0);

        // ---- load-use lasts one cycle and counts once
        reset_pulse();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
        @(negedge clk);
        check("lu_cnt_before", StallCount, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("lu_released", {StallF, StallD, FlushE}, 3'b000);
        check("lu_stall_cnt", StallCount, 1);
        check("lu_flush_cnt", FlushCount, 1);
        next_cycle();
        check("lu_stall_cnt_hold", StallCount, 1);

        // ---- multi-cycle op, MulStartE held high
        reset_pulse();
        MulStartE = 1'b1;
        @(negedge clk);
        check("mc0", {MulBusy, StallE, FlushM, StallD, StallF}, 5'b11111);
        check("mc0_lat1", {l_busy, l_se, l_fm, l_sd}, 4'b0000);
        next_cycle();
        BranchTakenE = 1'b1;
        @(negedge clk);
        check("mc1", {MulBusy, StallE, FlushM, StallD}, 4'b1111);
        check("mc1_masked", {FlushD, FlushE}, 2'b00);
        check("mc1_lat1_br", {l_fd, l_fe, l_se}, 3'b110);
        next_cycle();
        BranchTakenE = 1'b0;
        @(negedge clk);
        check("mc2", {StallE, FlushM, StallD, StallF}, 4'b0000);
        next_cycle();
        MulStartE = 1'b0;
        @(negedge clk);
        check("mc3_idle", {MulBusy, StallE, FlushM}, 3'b000);

        // ---- reset in the middle of a multi-cycle op
        reset_pulse();
        MulStartE = 1'b1;
        next_cycle();
        MulStartE = 1'b0;
        #2;
        check("mid_busy", {MulBusy, StallE}, 2'b11);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", {MulBusy, StallE, FlushM}, 3'b000);
        check("mid_reset_cnt", {StallCount, FlushCount}, 32'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ctl", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy}, 7'b0);
        check("post_reset_fwd", {ForwardAE, ForwardBE}, 4'b0);
        next_cycle();
        check("post_reset_cnt", {StallCount, FlushCount}, 32'b0);

        // ---- saturation on the 2-bit counters, then clear
        reset_pulse();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd7; RA1D = 4'd7;
        for (int i = 0; i < 5; i++) next_cycle();
        check("sat_stall", s_scnt, 2'd3);
        check("sat_flush", s_fcnt, 2'd3);
        check("sat_wide", StallCount, 5);
        CntClr = 1'b1;
        next_cycle();
        check("clr_stall", s_scnt, 2'd0);
        check("clr_flush", s_fcnt, 2'd0);
        check("clr_wide", StallCount, 0);
        CntClr = 1'b0;
        next_cycle();
        check("after_clr", s_scnt, 2'd1);
        idle_inputs();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_unit_mc
